// File: rtl/mips_hazard_unit_pkg.sv
// rtl/mips_hazard_unit_pkg.sv - shared types and helpers for the MIPS pipeline hazard unit
package mips_hazard_unit_pkg;

    localparam int REG_ADDR_W_DEF = 5;
    localparam int COUNT_W_DEF    = 16;

    // EX operand source select
    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_t;

    // Clock + reset bundle; resetn is synchronous active-low
    typedef struct packed {
        logic clk;
        logic resetn;
    } util_control_t;

    // MEM result is the youngest producer, so it wins over WB
    function automatic fwd_t fwd_pick(input logic mem_hit, input logic wb_hit);
        if (mem_hit) begin
            return FWD_MEM;
        end
        if (wb_hit) begin
            return FWD_WB;
        end
        return FWD_REG;
    endfunction

endpackage

// File: rtl/mips_hazard_unit_if.sv
// rtl/mips_hazard_unit_if.sv - pipeline-to-hazard-unit signal bundle
interface mips_hazard_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int COUNT_W    = 16
);
    // Decoded ID-stage instruction
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_use_rs;
    logic                  id_use_rt;
    logic                  id_wr_en;
    logic [REG_ADDR_W-1:0] id_wr_addr;
    logic                  id_is_load;

    // Late pipeline events
    logic                  ex_redirect;
    logic                  mem_ready;

    // Sequencing controls back to the pipeline
    logic                  stall_if;
    logic                  stall_id;
    logic                  bubble_ex;
    logic                  flush_id;
    logic                  freeze;
    logic [1:0]            fwd_a;
    logic [1:0]            fwd_b;
    logic                  ex_valid;
    logic                  mem_valid;
    logic                  wb_valid;
    logic [COUNT_W-1:0]    stall_count;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
        output id_wr_en, id_wr_addr, id_is_load, ex_redirect, mem_ready,
        input  stall_if, stall_id, bubble_ex, flush_id, freeze,
        input  fwd_a, fwd_b, ex_valid, mem_valid, wb_valid, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
        input  id_wr_en, id_wr_addr, id_is_load, ex_redirect, mem_ready,
        output stall_if, stall_id, bubble_ex, flush_id, freeze,
        output fwd_a, fwd_b, ex_valid, mem_valid, wb_valid, stall_count
    );

endinterface

// File: rtl/mips_fwd_select.sv
// rtl/mips_fwd_select.sv - per-operand forwarding select for the EX stage
module mips_fwd_select
    import mips_hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  src_used,
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  mem_valid,
    input  logic                  mem_wr_en,
    input  logic                  mem_is_load,
    input  logic [REG_ADDR_W-1:0] mem_wr_addr,
    input  logic                  wb_valid,
    input  logic                  wb_wr_en,
    input  logic [REG_ADDR_W-1:0] wb_wr_addr,
    output fwd_t                  sel
);

    logic mem_hit;
    logic wb_hit;

    // A load in MEM has no data yet, so it can only be forwarded once it reaches WB
    always_comb begin
        mem_hit = src_used & mem_valid & mem_wr_en & ~mem_is_load
                & (mem_wr_addr != '0) & (mem_wr_addr == src);
        wb_hit  = src_used & wb_valid & wb_wr_en
                & (wb_wr_addr != '0) & (wb_wr_addr == src);
        sel     = fwd_pick(mem_hit, wb_hit);
    end

endmodule

// File: rtl/mips_hazard_unit.sv
// rtl/mips_hazard_unit.sv - stall, bubble, flush, freeze and forwarding control for the 5-stage core
module mips_hazard_unit
    import mips_hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int COUNT_W    = COUNT_W_DEF
) (
    input util_control_t      ctrl,
    mips_hazard_unit_if.slave hz
);

    // Destination tracking for EX and MEM
    typedef struct packed {
        logic                  valid;
        logic                  wr_en;
        logic [REG_ADDR_W-1:0] wr_addr;
        logic                  is_load;
    } stage_t;

    // A load in WB already has its data, so the load flag is dropped here
    typedef struct packed {
        logic                  valid;
        logic                  wr_en;
        logic [REG_ADDR_W-1:0] wr_addr;
    } wb_stage_t;

    // Sources of the instruction sitting in EX
    typedef struct packed {
        logic                  use_rs;
        logic                  use_rt;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
    } src_t;

    logic clk;
    logic resetn;

    stage_t             ex_q, ex_d;
    stage_t             mem_q, mem_d;
    wb_stage_t          wb_q, wb_d;
    src_t               ex_src_q, ex_src_d;
    logic [COUNT_W-1:0] stall_count_q, stall_count_d;

    logic mem_wait;
    logic redirect;
    logic rs_hit;
    logic rt_hit;
    logic load_use;
    logic stall_if;
    logic stall_id;
    logic bubble_ex;
    logic flush_id;
    fwd_t fwd_a;
    fwd_t fwd_b;

    assign clk    = ctrl.clk;
    assign resetn = ctrl.resetn;

    // Raw hazard conditions from the tracked stages and the ID instruction
    always_comb begin
        mem_wait = mem_q.valid & ~hz.mem_ready;
        redirect = ex_q.valid & hz.ex_redirect;
        rs_hit   = hz.id_use_rs & (hz.id_rs == ex_q.wr_addr);
        rt_hit   = hz.id_use_rt & (hz.id_rt == ex_q.wr_addr);
        load_use = hz.id_valid & ex_q.valid & ex_q.is_load
                 & (ex_q.wr_addr != '0) & (rs_hit | rt_hit);
    end

    // Priority: memory wait freezes everything, then redirect, then load-use
    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        bubble_ex = 1'b0;
        flush_id  = 1'b0;
        if (mem_wait) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
        end else if (redirect) begin
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
        end else if (load_use) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
        end
    end

    // Advance the tracked stages unless frozen; a bubble or empty ID enters EX as invalid
    always_comb begin
        ex_d     = ex_q;
        ex_src_d = ex_src_q;
        mem_d    = mem_q;
        wb_d     = wb_q;
        if (!mem_wait) begin
            wb_d.valid   = mem_q.valid;
            wb_d.wr_en   = mem_q.wr_en;
            wb_d.wr_addr = mem_q.wr_addr;
            mem_d        = ex_q;
            if (bubble_ex || !hz.id_valid) begin
                ex_d     = '0;
                ex_src_d = '0;
            end else begin
                ex_d.valid      = 1'b1;
                ex_d.wr_en      = hz.id_wr_en;
                ex_d.wr_addr    = hz.id_wr_addr;
                ex_d.is_load    = hz.id_is_load;
                ex_src_d.use_rs = hz.id_use_rs;
                ex_src_d.use_rt = hz.id_use_rt;
                ex_src_d.rs     = hz.id_rs;
                ex_src_d.rt     = hz.id_rt;
            end
        end
    end

    // Saturating count of cycles lost to stalls or memory waits
    always_comb begin
        stall_count_d = stall_count_q;
        if ((stall_id || mem_wait) && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + COUNT_W'(1);
        end
    end

    // State registers; reset drops any pending stall or freeze
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ex_q          <= '0;
            ex_src_q      <= '0;
            mem_q         <= '0;
            wb_q          <= '0;
            stall_count_q <= '0;
        end else begin
            ex_q          <= ex_d;
            ex_src_q      <= ex_src_d;
            mem_q         <= mem_d;
            wb_q          <= wb_d;
            stall_count_q <= stall_count_d;
        end
    end

    mips_fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .src_used    (ex_q.valid & ex_src_q.use_rs),
        .src         (ex_src_q.rs),
        .mem_valid   (mem_q.valid),
        .mem_wr_en   (mem_q.wr_en),
        .mem_is_load (mem_q.is_load),
        .mem_wr_addr (mem_q.wr_addr),
        .wb_valid    (wb_q.valid),
        .wb_wr_en    (wb_q.wr_en),
        .wb_wr_addr  (wb_q.wr_addr),
        .sel         (fwd_a)
    );

    mips_fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .src_used    (ex_q.valid & ex_src_q.use_rt),
        .src         (ex_src_q.rt),
        .mem_valid   (mem_q.valid),
        .mem_wr_en   (mem_q.wr_en),
        .mem_is_load (mem_q.is_load),
        .mem_wr_addr (mem_q.wr_addr),
        .wb_valid    (wb_q.valid),
        .wb_wr_en    (wb_q.wr_en),
        .wb_wr_addr  (wb_q.wr_addr),
        .sel         (fwd_b)
    );

    assign hz.stall_if    = stall_if;
    assign hz.stall_id    = stall_id;
    assign hz.bubble_ex   = bubble_ex;
    assign hz.flush_id    = flush_id;
    assign hz.freeze      = mem_wait;
    assign hz.fwd_a       = fwd_a;
    assign hz.fwd_b       = fwd_b;
    assign hz.ex_valid    = ex_q.valid;
    assign hz.mem_valid   = mem_q.valid;
    assign hz.wb_valid    = wb_q.valid;
    assign hz.stall_count = stall_count_q;

endmodule

// File: tb/tb_mips_hazard_unit.sv
// tb/tb_mips_hazard_unit.sv - directed table and randomized model check of mips_hazard_unit
module tb_mips_hazard_unit;
    import mips_hazard_unit_pkg::*;

    typedef struct {
        int v;
        int rs;
        int rt;
        int urs;
        int urt;
        int we;
        int wa;
        int ld;
    } ins_t;

    typedef struct {
        int       rstn;
        ins_t     id;
        int       redir;
        int       mrdy;
        bit [12:0] exp;
        int       cnt;
    } vec_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    util_control_t ctrl;

    int n_total = 0;
    int n_pass = 0;

    vec_t vq[$];
    ins_t pipe[3];
    int   m_cnt;

    always #5 clk = ~clk;

    assign ctrl.clk    = clk;
    assign ctrl.resetn = resetn;

    mips_hazard_unit_if #(.REG_ADDR_W(5), .COUNT_W(16)) hz ();
    mips_hazard_unit_if #(.REG_ADDR_W(5), .COUNT_W(2))  hs ();

    assign hs.id_valid    = hz.id_valid;
    assign hs.id_rs       = hz.id_rs;
    assign hs.id_rt       = hz.id_rt;
    assign hs.id_use_rs   = hz.id_use_rs;
    assign hs.id_use_rt   = hz.id_use_rt;
    assign hs.id_wr_en    = hz.id_wr_en;
    assign hs.id_wr_addr  = hz.id_wr_addr;
    assign hs.id_is_load  = hz.id_is_load;
    assign hs.ex_redirect = hz.ex_redirect;
    assign hs.mem_ready   = hz.mem_ready;

    mips_hazard_unit #(.REG_ADDR_W(5), .COUNT_W(16)) dut (
        .ctrl (ctrl),
        .hz   (hz)
    );

    mips_hazard_unit #(.REG_ADDR_W(5), .COUNT_W(2)) dut_sat (
        .ctrl (ctrl),
        .hz   (hs)
    );

    function automatic ins_t nop();
        ins_t r;
        r = '{v: 0, rs: 0, rt: 0, urs: 0, urt: 0, we: 0, wa: 0, ld: 0};
        return r;
    endfunction

    function automatic ins_t alu(int d, int s, int t);
        ins_t r;
        r = '{v: 1, rs: s, rt: t, urs: 1, urt: 1, we: 1, wa: d, ld: 0};
        return r;
    endfunction

    function automatic ins_t lw(int d, int b);
        ins_t r;
        r = '{v: 1, rs: b, rt: 0, urs: 1, urt: 0, we: 1, wa: d, ld: 1};
        return r;
    endfunction

    // {stall_if, stall_id, bubble_ex, flush_id, freeze, fwd_a, fwd_b, ex_v, mem_v, wb_v}
    function automatic bit [12:0] o(int sif, int sid, int bub, int fl, int frz,
                                    int fa, int fb, int exv, int memv, int wbv);
        return {1'(sif), 1'(sid), 1'(bub), 1'(fl), 1'(frz), 2'(fa), 2'(fb),
                1'(exv), 1'(memv), 1'(wbv)};
    endfunction

    function automatic void add_vec(int rstn, ins_t id, int redir, int mrdy, bit [12:0] e, int cnt);
        vec_t v;
        v.rstn = rstn; v.id = id; v.redir = redir; v.mrdy = mrdy; v.exp = e; v.cnt = cnt;
        vq.push_back(v);
    endfunction

    task automatic drive(int rstn, ins_t i, int redir, int mrdy);
        resetn         = 1'(rstn);
        hz.id_valid    = 1'(i.v);
        hz.id_rs       = 5'(i.rs);
        hz.id_rt       = 5'(i.rt);
        hz.id_use_rs   = 1'(i.urs);
        hz.id_use_rt   = 1'(i.urt);
        hz.id_wr_en    = 1'(i.we);
        hz.id_wr_addr  = 5'(i.wa);
        hz.id_is_load  = 1'(i.ld);
        hz.ex_redirect = 1'(redir);
        hz.mem_ready   = 1'(mrdy);
    endtask

    task automatic chk(string nm, int idx, int act, int exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s[%0d] got=%h expected=%h", nm, idx, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic compare(string nm, int idx, bit [12:0] e, int cnt);
        bit [12:0] a;
        bit [12:0] s;
        a = {hz.stall_if, hz.stall_id, hz.bubble_ex, hz.flush_id, hz.freeze, hz.fwd_a, hz.fwd_b,
             hz.ex_valid, hz.mem_valid, hz.wb_valid};
        s = {hs.stall_if, hs.stall_id, hs.bubble_ex, hs.flush_id, hs.freeze, hs.fwd_a, hs.fwd_b,
             hs.ex_valid, hs.mem_valid, hs.wb_valid};
        chk(nm, idx, int'({a, hz.stall_count}), int'({e, 16'(cnt)}));
        chk({nm, "_sat"}, idx, int'({s, hs.stall_count}), int'({e, 2'(cnt > 3 ? 3 : cnt)}));
    endtask

    // Reference model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB
    function automatic int m_fwd(int src, int used);
        if (pipe[0].v == 0 || used == 0 || src == 0) return 0;
        if (pipe[1].v != 0 && pipe[1].we != 0 && pipe[1].ld == 0 && pipe[1].wa == src) return 1;
        if (pipe[2].v != 0 && pipe[2].we != 0 && pipe[2].wa == src) return 2;
        return 0;
    endfunction

    function automatic bit m_reads(ins_t i, int r);
        return (r != 0) && ((i.urs != 0 && i.rs == r) || (i.urt != 0 && i.rt == r));
    endfunction

    initial begin
        ins_t id;
        int redir, mrdy, rstn;
        bit frz, rd, lu;
        int fa, fb;
        bit [12:0] e;

        // Directed sequence, run from a clean reset
        add_vec(1, nop(),        0, 1, o(0,0,0,0,0, 0,0, 0,0,0), 0);
        add_vec(1, alu(3,1,2),   0, 1, o(0,0,0,0,0, 0,0, 0,0,0), 0);
        add_vec(1, alu(4,3,5),   0, 1, o(0,0,0,0,0, 0,0, 1,0,0), 0);
        add_vec(1, alu(6,5,3),   0, 1, o(0,0,0,0,0, 1,0, 1,1,0), 0);
        add_vec(1, nop(),        0, 1, o(0,0,0,0,0, 0,2, 1,1,1), 0);
        add_vec(1, lw(3,0),      0, 1, o(0,0,0,0,0, 0,0, 0,1,1), 0);
        add_vec(1, alu(4,3,3),   0, 1, o(1,1,1,0,0, 0,0, 1,0,1), 0);
        add_vec(1, alu(4,3,3),   0, 1, o(0,0,0,0,0, 0,0, 0,1,0), 1);
        add_vec(1, nop(),        0, 1, o(0,0,0,0,0, 2,2, 1,0,1), 1);
        add_vec(1, lw(7,0),      0, 1, o(0,0,0,0,0, 0,0, 0,1,0), 1);
        add_vec(1, nop(),        0, 1, o(0,0,0,0,0, 0,0, 1,0,1), 1);
        add_vec(1, nop(),        0, 0, o(1,1,0,0,1, 0,0, 0,1,0), 1);
        add_vec(1, nop(),        0, 0, o(1,1,0,0,1, 0,0, 0,1,0), 2);
        add_vec(1, nop(),        0, 0, o(1,1,0,0,1, 0,0, 0,1,0), 3);
        add_vec(1, nop(),        0, 1, o(0,0,0,0,0, 0,0, 0,1,0), 4);
        add_vec(1, lw(3,0),      0, 1, o(0,0,0,0,0, 0,0, 0,0,1), 4);
        add_vec(1, alu(4,3,3),   1, 1, o(0,0,1,1,0, 0,0, 1,0,0), 4);
        add_vec(1, nop(),        0, 1, o(0,0,0,0,0, 0,0, 0,1,0), 4);
        add_vec(1, alu(0,1,2),   0, 1, o(0,0,0,0,0, 0,0, 0,0,1), 4);
        add_vec(1, alu(5,0,0),   0, 1, o(0,0,0,0,0, 0,0, 1,0,0), 4);
        add_vec(1, lw(0,0),      0, 1, o(0,0,0,0,0, 0,0, 1,1,0), 4);
        add_vec(1, alu(6,0,0),   0, 1, o(0,0,0,0,0, 0,0, 1,1,1), 4);
        add_vec(1, nop(),        0, 1, o(0,0,0,0,0, 0,0, 1,1,1), 4);
        add_vec(0, nop(),        0, 0, o(1,1,0,0,1, 0,0, 0,1,1), 4);
        add_vec(1, nop(),        0, 0, o(0,0,0,0,0, 0,0, 0,0,0), 0);
        add_vec(1, lw(3,0),      0, 1, o(0,0,0,0,0, 0,0, 0,0,0), 0);
        add_vec(0, alu(4,3,3),   0, 1, o(1,1,1,0,0, 0,0, 1,0,0), 0);
        add_vec(1, alu(4,3,3),   0, 1, o(0,0,0,0,0, 0,0, 0,0,0), 0);

        drive(0, nop(), 0, 1);
        repeat (2) @(posedge clk);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i].rstn, vq[i].id, vq[i].redir, vq[i].mrdy);
            #1;
            compare("vec", i, vq[i].exp, vq[i].cnt);
        end

        // Randomized phase against the reference model
        @(negedge clk);
        drive(0, nop(), 0, 1);
        repeat (2) @(posedge clk);
        for (int s = 0; s < 3; s++) pipe[s] = nop();
        m_cnt = 0;

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            id.v   = ($urandom_range(0, 7) != 0) ? 1 : 0;
            id.rs  = int'($urandom_range(0, 3));
            id.rt  = int'($urandom_range(0, 3));
            id.urs = int'($urandom_range(0, 1));
            id.urt = int'($urandom_range(0, 1));
            id.we  = int'($urandom_range(0, 1));
            id.wa  = int'($urandom_range(0, 3));
            id.ld  = ($urandom_range(0, 2) == 0) ? 1 : 0;
            redir  = ($urandom_range(0, 7) == 0) ? 1 : 0;
            mrdy   = ($urandom_range(0, 3) != 0) ? 1 : 0;
            rstn   = ($urandom_range(0, 99) != 0) ? 1 : 0;
            drive(rstn, id, redir, mrdy);
            #1;

            frz = (pipe[1].v != 0) && (mrdy == 0);
            rd  = (pipe[0].v != 0) && (redir != 0);
            lu  = (id.v != 0) && (pipe[0].v != 0) && (pipe[0].ld != 0) && m_reads(id, pipe[0].wa);
            fa  = m_fwd(pipe[0].rs, pipe[0].urs);
            fb  = m_fwd(pipe[0].rt, pipe[0].urt);
            if (frz)     e = o(1,1,0,0,1, fa,fb, pipe[0].v, pipe[1].v, pipe[2].v);
            else if (rd) e = o(0,0,1,1,0, fa,fb, pipe[0].v, pipe[1].v, pipe[2].v);
            else if (lu) e = o(1,1,1,0,0, fa,fb, pipe[0].v, pipe[1].v, pipe[2].v);
            else         e = o(0,0,0,0,0, fa,fb, pipe[0].v, pipe[1].v, pipe[2].v);
            compare("rand", c, e, m_cnt);

            @(posedge clk);
            if (rstn == 0) begin
                for (int s = 0; s < 3; s++) pipe[s] = nop();
                m_cnt = 0;
            end else begin
                if ((frz || (lu && !rd)) && m_cnt < 65535) m_cnt++;
                if (!frz) begin
                    pipe[2] = pipe[1];
                    pipe[1] = pipe[0];
                    pipe[0] = (rd || lu || id.v == 0) ? nop() : id;
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
